// File: rtl/uart_cmd_decoder.sv
// Byte-level host command parser: assembles 2/3-byte UART frames into one I2C request,
// optionally gated by the sensor data-ready pin, with inter-byte and data-ready timeouts.
module uart_cmd_decoder #(
  parameter int BYTE_TIMEOUT = 50000,
  parameter int INT_TIMEOUT  = 1000000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       int_pin,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [6:0] req_addr,
  output logic       req_rw,
  output logic [6:0] req_reg,
  output logic [7:0] req_wdata,
  output logic       req_conv,
  output logic       busy,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_REG,
    S_GET_DATA,
    S_WAIT_INT,
    S_ISSUE
  } state_t;

  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INT_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_int_meta;
  logic             r_int_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_addr;
  logic             r_rw;
  logic [6:0]       r_reg;
  logic [7:0]       r_wdata;
  logic             r_conv;
  logic             r_err_pulse;
  logic [1:0]       r_err_code;
  logic             w_tready;
  logic             w_accept;
  logic             w_byte_to;
  logic             w_int_to;

  // INT is asynchronous and active low; idle level is high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_int_meta <= 1'b1;
      r_int_sync <= 1'b1;
    end else begin
      r_int_meta <= int_pin;
      r_int_sync <= r_int_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // A byte arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    w_state_next = r_state;
    w_tready     = 1'b0;
    w_byte_to    = 1'b0;
    w_int_to     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) w_state_next = S_GET_REG;
      end
      S_GET_REG: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (!r_rw)                w_state_next = S_GET_DATA;
          else if (s_axis_tdata[7]) w_state_next = S_WAIT_INT;
          else                      w_state_next = S_ISSUE;
        end else if (r_cnt == BYTE_LAST) begin
          w_byte_to    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_GET_DATA: begin
        w_tready = 1'b1;
        if (s_axis_tvalid) begin
          w_state_next = r_conv ? S_WAIT_INT : S_ISSUE;
        end else if (r_cnt == BYTE_LAST) begin
          w_byte_to    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_INT: begin
        if (!r_int_sync) begin
          w_state_next = S_ISSUE;
        end else if (r_cnt == INT_LAST) begin
          w_int_to     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (req_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = s_axis_tvalid & w_tready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == S_GET_REG) || (r_state == S_GET_DATA) || (r_state == S_WAIT_INT)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Byte0 also clears wdata/conv so read frames report wdata = 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_reg   <= '0;
      r_wdata <= '0;
      r_conv  <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          r_addr  <= s_axis_tdata[7:1];
          r_rw    <= s_axis_tdata[0];
          r_wdata <= '0;
          r_conv  <= 1'b0;
        end
        S_GET_REG: begin
          r_conv <= s_axis_tdata[7];
          r_reg  <= s_axis_tdata[6:0];
        end
        S_GET_DATA: r_wdata <= s_axis_tdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_pulse <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_err_pulse <= w_byte_to | w_int_to;
      if (w_byte_to)     r_err_code <= 2'b01;
      else if (w_int_to) r_err_code <= 2'b10;
    end
  end

  assign s_axis_tready = w_tready;
  assign req_valid     = (r_state == S_ISSUE);
  assign busy          = (r_state != S_IDLE);
  assign req_addr      = r_addr;
  assign req_rw        = r_rw;
  assign req_reg       = r_reg;
  assign req_wdata     = r_wdata;
  assign req_conv      = r_conv;
  assign err_pulse     = r_err_pulse;
  assign err_code      = r_err_code;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: expected requests queued at stimulus time and
// compared when the decoder presents them; errors, latency and reset checked inline.
module tb_uart_cmd_decoder;

  localparam int BT = 20;
  localparam int IT = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       int_pin = 1'b1;
  logic       req_valid;
  logic       req_ready = 1'b0;
  logic [6:0] req_addr;
  logic       req_rw;
  logic [6:0] req_reg;
  logic [7:0] req_wdata;
  logic       req_conv;
  logic       busy;
  logic       err_pulse;
  logic [1:0] err_code;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [6:0] rg;
    logic [7:0] wdata;
    logic       conv;
  } req_t;

  req_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_cmd_decoder #(.BYTE_TIMEOUT(BT), .INT_TIMEOUT(IT), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .int_pin(int_pin),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_rw(req_rw), .req_reg(req_reg),
    .req_wdata(req_wdata), .req_conv(req_conv),
    .busy(busy), .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] a, input logic rw, input logic [6:0] rg,
                          input logic [7:0] wd, input logic cv);
    req_t e;
    e.addr = a; e.rw = rw; e.rg = rg; e.wdata = wd; e.conv = cv;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_byte_tready_timeout", 32'(n), 0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    $display("[TB] byte 0x%02h accepted", b);
  endtask

  task automatic expect_req(input string tag);
    req_t e;
    int   n = 0;
    req_ready = 1'b1;
    while (!req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(req_valid), 1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_addr"}, 32'(req_addr), 32'(e.addr));
      check({tag, "_rw"}, 32'(req_rw), 32'(e.rw));
      check({tag, "_reg"}, 32'(req_reg), 32'(e.rg));
      check({tag, "_wdata"}, 32'(req_wdata), 32'(e.wdata));
      check({tag, "_conv"}, 32'(req_conv), 32'(e.conv));
    end
    $display("[TB] %s request addr=%02h rw=%0d reg=%02h wdata=%02h conv=%0d",
             tag, req_addr, req_rw, req_reg, req_wdata, req_conv);
    @(negedge clk);
    req_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(req_valid), 0);
    check({tag, "_done_busy"}, 32'(busy), 0);
    check({tag, "_done_tready"}, 32'(s_axis_tready), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tready"}, 32'(s_axis_tready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_valid"}, 32'(req_valid), 0);
    check({tag, "_addr"}, 32'(req_addr), 0);
    check({tag, "_reg"}, 32'(req_reg), 0);
    check({tag, "_wdata"}, 32'(req_wdata), 0);
    check({tag, "_errp"}, 32'(err_pulse), 0);
    check({tag, "_errc"}, 32'(err_code), 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 1. plain read frame, request one cycle after last byte
    push_exp(7'h34, 1'b1, 7'h00, 8'h00, 1'b0);
    send_byte(8'h69);
    send_byte(8'h00);
    check("t1_latency", 32'(req_valid), 1);
    expect_req("t1");

    // 2. conversion read gated by INT
    push_exp(7'h34, 1'b1, 7'h00, 8'h00, 1'b1);
    send_byte(8'h69);
    send_byte(8'h80);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_no_valid", 32'(req_valid), 0);
      @(negedge clk);
    end
    check("t2_busy", 32'(busy), 1);
    int_pin = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_valid && n < 8);
    check("t2_int_latency_le4", 32'(req_valid && n <= 4), 1);
    expect_req("t2");
    int_pin = 1'b1;
    repeat (3) @(negedge clk);

    // 3. write frame held under back-pressure
    push_exp(7'h34, 1'b0, 7'h14, 8'hA5, 1'b0);
    send_byte(8'h68);
    send_byte(8'h14);
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", 32'(req_valid), 1);
      check("t3_hold_tready", 32'(s_axis_tready), 0);
      check("t3_hold_fields", {12'd0, req_addr, req_reg, req_wdata, req_rw},
            {12'd0, 7'h34, 7'h14, 8'hA5, 1'b0});
      @(negedge clk);
    end
    expect_req("t3");

    // 4. byte timeout, then accept-on-expiry boundary
    send_byte(8'h69);
    n = 0;
    while (!err_pulse && n < BT + 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_timeout_cycles", 32'(n), 32'(BT));
    check("t4_errp", 32'(err_pulse), 1);
    check("t4_errc", 32'(err_code), 32'h1);
    check("t4_busy", 32'(busy), 0);
    check("t4_no_valid", 32'(req_valid), 0);
    @(negedge clk);
    check("t4_errp_one_cycle", 32'(err_pulse), 0);
    push_exp(7'h34, 1'b1, 7'h05, 8'h00, 1'b0);
    send_byte(8'h69);
    repeat (BT - 1) @(negedge clk);
    send_byte(8'h05);
    check("t4_edge_valid", 32'(req_valid), 1);
    check("t4_edge_no_errp", 32'(err_pulse), 0);
    expect_req("t4");
    check("t4_errc_held", 32'(err_code), 32'h1);

    // 5. INT timeout
    send_byte(8'h69);
    send_byte(8'h80);
    n = 0;
    while (!err_pulse && n < IT + 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_cycles", 32'(n), 32'(IT));
    check("t5_errc", 32'(err_code), 32'h2);
    check("t5_busy", 32'(busy), 0);
    check("t5_no_valid", 32'(req_valid), 0);

    // 6. reset in GET_DATA and in ISSUE, then a fresh frame
    send_byte(8'h68);
    send_byte(8'h14);
    check("t6_in_get_data_busy", 32'(busy), 1);
    rstn = 1'b0;
    #1;
    check_reset_values("t6_rst_get_data");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_byte(8'h69);
    send_byte(8'h00);
    check("t6_in_issue_valid", 32'(req_valid), 1);
    rstn = 1'b0;
    #1;
    check_reset_values("t6_rst_issue");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_no_stale_valid", 32'(req_valid), 0);
    push_exp(7'h34, 1'b0, 7'h01, 8'h3C, 1'b0);
    send_byte(8'h68);
    send_byte(8'h01);
    send_byte(8'h3C);
    expect_req("t6");
    check("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
